// File: rtl/aes256_cipher_core_pkg.sv
// Shared AES definitions for the iterative AES-256 cipher core:
// FSM state encoding, block/round constants and GF(2^8) helpers.
package aes256_cipher_core_pkg;

    localparam int AES_NR    = 14;
    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_KEY = 2'd1,
        ST_ROUND    = 2'd2,
        ST_DONE     = 2'd3
    } aes_state_e;

    // Forward S-box, entry 0 first.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes256_cipher_core_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped
// on the final round) and AddRoundKey. Byte 0 of a block is bits [127:120];
// state column c holds bytes 4c..4c+3, row r of column c is byte 4c+r.
module aes256_cipher_core_round
    import aes256_cipher_core_pkg::*;
(
    input  logic [AES_BLK_W-1:0] state_i,
    input  logic [AES_BLK_W-1:0] round_key_i,
    input  logic                 final_i,
    output logic [AES_BLK_W-1:0] state_o
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // Round transform on the whole block
    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path can leave it unassigned and infer a latch.
        sb      = '{default: 8'h00};
        sr      = '{default: 8'h00};
        mc      = '{default: 8'h00};
        state_o = '0;

        for (int i = 0; i < 16; i++) begin
            sb[i] = sub_byte(state_i[127-8*i -: 8]);
        end

        // Row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end

        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end

        for (int i = 0; i < 16; i++) begin
            state_o[127-8*i -: 8] = (final_i ? sr[i] : mc[i]) ^ round_key_i[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes256_cipher_core.sv
// Iterative AES-256 encryption core, one round per clock, reading round keys
// from an upstream key-expansion block through key_addr/round_key.
// Optional feature: define AES_CT_HOLD_EN to give ciphertext its own register
// that holds the last result; otherwise ciphertext is the live state register.
module aes256_cipher_core
    import aes256_cipher_core_pkg::*;
#(
    parameter int NR         = AES_NR,
    parameter int KEY_ADDR_W = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic [AES_BLK_W-1:0]  plaintext,
    input  logic                  key_ready,
    input  logic [AES_BLK_W-1:0]  round_key,
    output logic [KEY_ADDR_W-1:0] key_addr,
    output logic                  busy,
    output logic                  done,
    output logic [AES_BLK_W-1:0]  ciphertext
);

    aes_state_e            state_q, state_d;
    logic [KEY_ADDR_W-1:0] cnt_q, cnt_d;
    logic [AES_BLK_W-1:0]  pt_q, pt_d;
    logic [AES_BLK_W-1:0]  blk_q, blk_d;
    logic [AES_BLK_W-1:0]  round_out;
    logic                  last_round;

    assign last_round = (cnt_q == KEY_ADDR_W'(NR));

    aes256_cipher_core_round u_round (
        .state_i     (blk_q),
        .round_key_i (round_key),
        .final_i     (last_round),
        .state_o     (round_out)
    );

    // FSM next state, round counter and state-register update selection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pt_d    = pt_q;
        blk_d   = blk_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pt_d = plaintext;
                    if (key_ready) begin
                        blk_d   = plaintext ^ round_key;
                        cnt_d   = KEY_ADDR_W'(1);
                        state_d = ST_ROUND;
                    end else begin
                        state_d = ST_WAIT_KEY;
                    end
                end
            end
            ST_WAIT_KEY: begin
                if (key_ready) begin
                    blk_d   = pt_q ^ round_key;
                    cnt_d   = KEY_ADDR_W'(1);
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                blk_d = round_out;
                if (last_round) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + KEY_ADDR_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and datapath registers; reset aborts to idle at once
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pt_q    <= '0;
            blk_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pt_q    <= pt_d;
            blk_q   <= blk_d;
        end
    end

    // cnt is zero outside ROUND, so it doubles as the key index everywhere.
    assign key_addr = cnt_q;
    assign busy     = (state_q == ST_WAIT_KEY) || (state_q == ST_ROUND);
    assign done     = (state_q == ST_DONE);

`ifdef AES_CT_HOLD_EN
    logic [AES_BLK_W-1:0] ct_q;

    // Result register, loaded only on the edge that enters DONE
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ct_q <= '0;
        end else if (state_q == ST_ROUND && last_round) begin
            ct_q <= round_out;
        end
    end

    assign ciphertext = ct_q;
`else
    assign ciphertext = blk_q;
`endif

endmodule

// File: tb/tb_aes256_cipher_core.sv
// Directed bench for aes256_cipher_core using the FIPS-197 C.3 AES-256 vector.
// Round keys come from a fixed table indexed by key_addr, standing in for the
// key-expansion block. Define AES_CT_HOLD_EN to check the held-result build.
module tb_aes256_cipher_core;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT     = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_ALT = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] JUNK   = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         start;
    logic         key_ready;
    logic [127:0] plaintext;
    logic [127:0] round_key;
    logic [3:0]   key_addr;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;

    logic [127:0] rk_tab [0:15];
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 Clk = ~Clk;

    // Key source: valid schedule only while key_ready is high.
    assign round_key = key_ready ? rk_tab[key_addr] : JUNK;

    aes256_cipher_core dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .start      (start),
        .plaintext  (plaintext),
        .key_ready  (key_ready),
        .round_key  (round_key),
        .key_addr   (key_addr),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done, counting falling edges until it is seen.
    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge Clk);
            cycles++;
        end while (!done && cycles < budget);
        check("done_seen", 128'(done), 128'(1));
    endtask

    initial begin
        int cyc;
        int busy_cnt;
        int pulses;

        rk_tab[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk_tab[1]  = 128'h101112131415161718191a1b1c1d1e1f;
        rk_tab[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
        rk_tab[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
        rk_tab[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
        rk_tab[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
        rk_tab[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
        rk_tab[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
        rk_tab[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
        rk_tab[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
        rk_tab[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
        rk_tab[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
        rk_tab[12] = 128'h2541fe719bf500258813bbd55a721c0a;
        rk_tab[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
        rk_tab[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
        rk_tab[15] = '0;

        // Reset state
        Rst       = 1'b0;
        start     = 1'b0;
        key_ready = 1'b1;
        plaintext = '0;
        repeat (2) @(negedge Clk);
        check("rst_status", 128'({busy, done, key_addr}), 128'(6'b00_0000));
        check("rst_ct", ciphertext, '0);
        Rst = 1'b1;
        @(negedge Clk);

        // Encryption with keys ready: key_addr trace, latency, result
        check("idle_key_addr", 128'(key_addr), 128'(0));
        start     = 1'b1;
        plaintext = PT;
        for (int k = 1; k <= 14; k++) begin
            @(negedge Clk);
            start     = 1'b0;
            plaintext = ~PT;
            check($sformatf("trace_r%0d", k), 128'({busy, done, key_addr}), 128'({2'b10, 4'(k)}));
        end
        @(negedge Clk);
        check("t1_done_status", 128'({busy, done, key_addr}), 128'(6'b01_0000));
        check("t1_ct", ciphertext, CT);
        start     = 1'b1;
        plaintext = PT_ALT;
        @(negedge Clk);
        start = 1'b0;
        check("start_in_done_ignored", 128'({busy, done, key_addr}), 128'(6'b00_0000));
        @(negedge Clk);

        // Keys not ready at start: wait 20 cycles, then 15-cycle latency
        key_ready = 1'b0;
        start     = 1'b1;
        plaintext = PT;
        busy_cnt  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            start     = 1'b0;
            plaintext = PT_ALT;
            if (busy && !done && key_addr == 4'd0) busy_cnt++;
        end
        check("wait_key_busy_cycles", 128'(busy_cnt), 128'(20));
        key_ready = 1'b1;
        wait_done(40, cyc);
        check("t2_latency", 128'(cyc), 128'(15));
        check("t2_ct", ciphertext, CT);
        @(negedge Clk);

        // Start pulsed mid-encryption with another plaintext is ignored
        start     = 1'b1;
        plaintext = PT;
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            start = 1'b0;
        end
        check("t3_at_round5", 128'(key_addr), 128'(5));
`ifdef AES_CT_HOLD_EN
        check("ct_held_mid_run", ciphertext, CT);
`else
        check("ct_live_mid_run", 128'(ciphertext !== CT), 128'(1));
`endif
        start     = 1'b1;
        plaintext = PT_ALT;
        @(negedge Clk);
        start = 1'b0;
        check("t3_round6", 128'({busy, done, key_addr}), 128'({2'b10, 4'd6}));
        wait_done(20, cyc);
        check("t3_latency_rest", 128'(cyc), 128'(9));
        check("t3_ct", ciphertext, CT);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            if (done || busy) pulses++;
        end
        check("t3_no_second_run", 128'(pulses), 128'(0));

        // Reset asserted at round 7, then a fresh encryption
        start     = 1'b1;
        plaintext = PT;
        for (int k = 1; k <= 7; k++) begin
            @(negedge Clk);
            start = 1'b0;
        end
        check("t4_at_round7", 128'(key_addr), 128'(7));
        Rst = 1'b0;
        #1;
        check("t4_abort_status", 128'({busy, done, key_addr}), 128'(6'b00_0000));
        check("t4_abort_ct", ciphertext, '0);
        @(negedge Clk);
        Rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            if (done || busy) pulses++;
        end
        check("t4_no_done_after_abort", 128'(pulses), 128'(0));
        start     = 1'b1;
        plaintext = PT;
        @(negedge Clk);
        start     = 1'b0;
        plaintext = '0;
        wait_done(20, cyc);
        check("t4_latency", 128'(cyc), 128'(14));
        check("t4_ct", ciphertext, CT);
        repeat (2) @(negedge Clk);
        check("ct_after_idle", ciphertext, CT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
